// File: rtl/multi_clock_divider_if.sv
// ---------------------------------------------------------------------------
// multi_clock_divider_if
// Groups the run controls, the divisor write bus and the divided outputs of
// multi_clock_divider.
//   enable   [CHANNELS]  per-channel run enable (0 freezes the channel)
//   mode     [CHANNELS]  per-channel divisor select, 1=slot 1, 0=slot 0
//   cfg_we               divisor write strobe, one cycle
//   cfg_ch   [3]         channel index for the write
//   cfg_slot             slot index for the write
//   cfg_data [CNT_W]     new divisor value
//   clk_out  [CHANNELS]  divided clocks, period 2*D
//   tick     [CHANNELS]  one-cycle strobe coincident with each clk_out toggle
// master: the controller driving the block; slave: the divider itself.
// ---------------------------------------------------------------------------
interface multi_clock_divider_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 24
);
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] mode;
    logic                cfg_we;
    logic [2:0]          cfg_ch;
    logic                cfg_slot;
    logic [CNT_W-1:0]    cfg_data;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;

    modport master (
        output enable, mode, cfg_we, cfg_ch, cfg_slot, cfg_data,
        input  clk_out, tick
    );

    modport slave (
        input  enable, mode, cfg_we, cfg_ch, cfg_slot, cfg_data,
        output clk_out, tick
    );
endinterface

// File: rtl/multi_clock_divider.sv
// ---------------------------------------------------------------------------
// multi_clock_divider
// CHANNELS independent glitch-free clock dividers. Each channel holds two
// programmable divisors and divides clk by the one chosen by its mode bit.
// Divisor/mode changes are only sampled when the channel's counter is 0,
// i.e. at half-period boundaries, so clk_out never produces a short pulse.
// Ports:
//   clk      system clock, rising edge only
//   reset_n  asynchronous active-low reset; divisors return to DIV_FAST/DIV_SLOW
//   bus      multi_clock_divider_if.slave (controls, config bus, outputs)
// Build option:
//   CLKDIV_SYNC_EN  when defined, enable and mode go through a 2-flop
//                   synchroniser (reset to 0), adding 2 cycles of latency.
// ---------------------------------------------------------------------------

// One divider channel.
module multi_clock_divider_ch #(
    parameter int CNT_W    = 24,
    parameter int DIV_FAST = 5,
    parameter int DIV_SLOW = 1_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    input  logic             i_mode,
    input  logic             i_we,      // write already decoded for this channel
    input  logic             i_slot,
    input  logic [CNT_W-1:0] i_data,
    output logic             o_clk_out,
    output logic             o_tick
);
    logic [CNT_W-1:0]            r_counter;
    logic [CNT_W-1:0]            r_active_div;
    logic [1:0][CNT_W-1:0]       r_div;
    logic                        r_clk_out;
    logic                        r_tick;

    logic [CNT_W-1:0] w_fresh;
    logic [CNT_W-1:0] w_fresh_eff;
    logic [CNT_W-1:0] w_active_eff;
    logic             w_terminal;

    // A divisor of 0 behaves as 1.
    assign w_fresh      = r_div[i_mode];
    assign w_fresh_eff  = (w_fresh == '0) ? CNT_W'(1) : w_fresh;
    assign w_active_eff = (r_active_div == '0) ? CNT_W'(1) : r_active_div;

    // At counter==0 the freshly selected divisor decides, so a D=1 half-period
    // ends in the same cycle it is latched.
    assign w_terminal = (r_counter == '0) ? (w_fresh_eff == CNT_W'(1))
                                          : (r_counter == w_active_eff - CNT_W'(1));

    // A write in the same cycle as a latch is seen by the latch only on the
    // following half-period (non-blocking read of the old value).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div[1] <= CNT_W'(DIV_FAST);
            r_div[0] <= CNT_W'(DIV_SLOW);
        end else if (i_we) begin
            r_div[i_slot] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter    <= '0;
            r_active_div <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else if (i_enable) begin
            if (r_counter == '0)
                r_active_div <= w_fresh;
            if (w_terminal) begin
                r_counter <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
            end else begin
                r_counter <= r_counter + CNT_W'(1);
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
endmodule

module multi_clock_divider #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 24,
    parameter int DIV_FAST = 5,
    parameter int DIV_SLOW = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    multi_clock_divider_if.slave  bus
);
    logic [CHANNELS-1:0] w_enable;
    logic [CHANNELS-1:0] w_mode;
    logic [CHANNELS-1:0] w_clk_out;
    logic [CHANNELS-1:0] w_tick;

`ifdef CLKDIV_SYNC_EN
    // Two-stage synchronisers so enable/mode can come straight from switches.
    logic [1:0][CHANNELS-1:0] r_en_sync;
    logic [1:0][CHANNELS-1:0] r_mode_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_sync   <= '0;
            r_mode_sync <= '0;
        end else begin
            r_en_sync   <= {r_en_sync[0],   bus.enable};
            r_mode_sync <= {r_mode_sync[0], bus.mode};
        end
    end

    assign w_enable = r_en_sync[1];
    assign w_mode   = r_mode_sync[1];
`else
    assign w_enable = bus.enable;
    assign w_mode   = bus.mode;
`endif

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic w_we;
            // cfg_ch values >= CHANNELS match no channel and are dropped.
            assign w_we = bus.cfg_we && (bus.cfg_ch == 3'(g));

            multi_clock_divider_ch #(
                .CNT_W    (CNT_W),
                .DIV_FAST (DIV_FAST),
                .DIV_SLOW (DIV_SLOW)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_enable  (w_enable[g]),
                .i_mode    (w_mode[g]),
                .i_we      (w_we),
                .i_slot    (bus.cfg_slot),
                .i_data    (bus.cfg_data),
                .o_clk_out (w_clk_out[g]),
                .o_tick    (w_tick[g])
            );
        end
    endgenerate

    assign bus.clk_out = w_clk_out;
    assign bus.tick    = w_tick;
endmodule

// File: tb/tb_multi_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_multi_clock_divider
// Directed bench for multi_clock_divider (CHANNELS=2, DIV_FAST=5,
// DIV_SLOW=1_000_000, CLKDIV_SYNC_EN undefined). Outputs are sampled 1 time
// unit after each rising edge; inputs change at the same point.
// ---------------------------------------------------------------------------
module tb_multi_clock_divider;
    localparam int CHANNELS = 2;
    localparam int CNT_W    = 24;

    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    multi_clock_divider_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    multi_clock_divider #(
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W),
        .DIV_FAST (5),
        .DIV_SLOW (1_000_000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.enable    = '0;
        bus.mode      = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_slot  = 1'b0;
        bus.cfg_data  = '0;

        // Reset state
        #1;
        chk("rst_clk_out", 32'(bus.clk_out), 0);
        chk("rst_tick",    32'(bus.tick),    0);
        repeat (3) step();
        chk("rst_clk_out_hold", 32'(bus.clk_out), 0);

        // ch0 at D=5: rise on 5th edge, toggle every 5, tick on each toggle
        reset_n    = 1'b1;
        bus.enable = 2'b01;
        bus.mode   = 2'b11;
        for (int n = 1; n <= 15; n++) begin
            step();
            chk($sformatf("d5_clk_e%0d", n),  32'(bus.clk_out[0]), 32'((n / 5) % 2));
            chk($sformatf("d5_tick_e%0d", n), 32'(bus.tick[0]),    32'(n % 5 == 0));
        end
        chk("d5_ch1_idle", 32'(bus.clk_out[1]), 0);

        // Pause 7 cycles with counter at 2; remaining 3 cycles finish the half
        step();
        step();
        chk("pre_pause_clk", 32'(bus.clk_out[0]), 1);
        bus.enable = 2'b00;
        for (int n = 1; n <= 7; n++) begin
            step();
            chk($sformatf("pause_clk_%0d", n),  32'(bus.clk_out[0]), 1);
            chk($sformatf("pause_tick_%0d", n), 32'(bus.tick[0]),    0);
        end
        bus.enable = 2'b01;
        for (int n = 1; n <= 3; n++) begin
            step();
            chk($sformatf("resume_clk_%0d", n),  32'(bus.clk_out[0]), 32'(n != 3));
            chk($sformatf("resume_tick_%0d", n), 32'(bus.tick[0]),    32'(n == 3));
        end

        // Slot0=20, run on mode 0, flip mode to 1 at counter=3
        bus.enable   = 2'b00;
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 3'd0;
        bus.cfg_slot = 1'b0;
        bus.cfg_data = 24'd20;
        step();
        bus.cfg_we = 1'b0;
        bus.mode   = 2'b10;
        bus.enable = 2'b01;
        for (int n = 1; n <= 20; n++) begin
            step();
            chk($sformatf("d20_clk_%0d", n),  32'(bus.clk_out[0]), 32'(n == 20));
            chk($sformatf("d20_tick_%0d", n), 32'(bus.tick[0]),    32'(n == 20));
            if (n == 3) bus.mode = 2'b11;
        end
        for (int n = 1; n <= 5; n++) begin
            step();
            chk($sformatf("after_mode_clk_%0d", n),  32'(bus.clk_out[0]), 32'(n != 5));
            chk($sformatf("after_mode_tick_%0d", n), 32'(bus.tick[0]),    32'(n == 5));
        end

        // Write slot1=1 in the same cycle as the latch: this half stays at 5
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 3'd0;
        bus.cfg_slot = 1'b1;
        bus.cfg_data = 24'd1;
        for (int n = 1; n <= 5; n++) begin
            step();
            bus.cfg_we = 1'b0;
            chk($sformatf("old_div_clk_%0d", n),  32'(bus.clk_out[0]), 32'(n == 5));
            chk($sformatf("old_div_tick_%0d", n), 32'(bus.tick[0]),    32'(n == 5));
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("d1_clk_%0d", k),  32'(bus.clk_out[0]), 32'(k % 2 == 0));
            chk($sformatf("d1_tick_%0d", k), 32'(bus.tick[0]),    1);
        end

        // Write to cfg_ch=5 must not touch ch1 (still D=5)
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 3'd5;
        bus.cfg_slot = 1'b1;
        bus.cfg_data = 24'd1;
        step();
        bus.cfg_we = 1'b0;
        bus.enable = 2'b11;
        for (int n = 1; n <= 17; n++) begin
            step();
            chk($sformatf("ch1_clk_%0d", n),  32'(bus.clk_out[1]), 32'((n / 5) % 2));
            chk($sformatf("ch1_tick_%0d", n), 32'(bus.tick[1]),    32'(n % 5 == 0));
            chk($sformatf("ch0_tick_%0d", n), 32'(bus.tick[0]),    1);
        end

        // Asynchronous reset mid half-period
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_clk_out", 32'(bus.clk_out), 0);
        chk("async_rst_tick",    32'(bus.tick),    0);
        step();
        step();
        reset_n    = 1'b1;
        bus.enable = 2'b11;
        bus.mode   = 2'b01;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("post_rst_ch0_clk_%0d", n),  32'(bus.clk_out[0]), 32'((n / 5) % 2));
            chk($sformatf("post_rst_ch0_tick_%0d", n), 32'(bus.tick[0]),    32'(n % 5 == 0));
            chk($sformatf("post_rst_ch1_clk_%0d", n),  32'(bus.clk_out[1]), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parameterised, multi-channel programmable clock divider for the board-level timing path. Each of CHANNELS independent channels divides the system clock by one of two runtime-programmable divisors, selected per channel by a mode input. Each channel produces a 50%-duty divided clock and a one-cycle tick strobe. Divisor and mode changes apply only at half-period boundaries, so the output never glitches. The block feeds display/counter logic that needs a fast (simulation/demo) rate and a slow (human-visible) rate from the same source.

## Interface
- CHANNELS, 2, number of independent divider channels (1..8)
- CNT_W, 24, counter and divisor width in bits
- DIV_FAST, 5, reset value of divisor slot 1 (selected when mode=1)
- DIV_SLOW, 1_000_000, reset value of divisor slot 0 (selected when mode=0)

- clk  in  1  system clock; all logic on rising edge only
- reset_n  in  1  asynchronous active-low reset
- enable  in  CHANNELS  per-channel run enable; 0 freezes the channel
- mode  in  CHANNELS  per-channel divisor select; 1=slot 1, 0=slot 0
- cfg_we  in  1  divisor write strobe, one cycle
- cfg_ch  in  3  channel index for the write
- cfg_slot  in  1  slot index for the write
- cfg_data  in  CNT_W  new divisor value
- clk_out  out  CHANNELS  divided clocks, period = 2*D cycles
- tick  out  CHANNELS  one-cycle strobe on every clk_out toggle

## Operation
- Per channel state:
  - counter[CNT_W]
  - div_reg[2][CNT_W]
  - active_div[CNT_W]
  - clk_out
  - tick
- Effective divisor D = selected value; value 0 is treated as 1.
- Each enabled cycle, the terminal condition is evaluated as follows:
  - If counter==0: latch active_div from the slot selected by the current mode, and compare using that fresh value. Terminal when the fresh D==1.
  - Otherwise: terminal when counter==active_div-1.
- On terminal: counter<=0, clk_out<=~clk_out, tick<=1.
- On non-terminal: counter<=counter+1, tick<=0.
- enable=0: counter, active_div and clk_out hold; tick<=0. Counting resumes from the held count when enable returns to 1.
- A mode change mid-half-period is ignored until counter next equals 0. The current half-period always completes at the old divisor.
- Configuration writes:
  - cfg_we=1 writes div_reg[cfg_slot] of channel cfg_ch.
  - If cfg_ch>=CHANNELS, the write is ignored with no side effects.
  - A new value takes effect at the channel's next counter==0 cycle, never mid-half-period.
- Simultaneous cfg write and counter==0 latch on the same channel/slot: the latch uses the OLD div_reg value. The new value applies from the following half-period.
- Channels are fully independent; no phase relationship is guaranteed between them.

## Timing
- Reset (asynchronous, reset_n low):
  - counter=0, clk_out=0, tick=0, active_div=0.
  - div_reg[1]=DIV_FAST, div_reg[0]=DIV_SLOW.
- First enabled cycle after reset release is counter==0 and latches the divisor.
- First clk_out rise is registered on the D-th enabled rising edge after release.
- tick is registered and high exactly in the cycle after the edge that toggles clk_out, i.e. coincident with the new clk_out level.
- D=1: clk_out toggles every cycle (period 2), and tick is held high continuously.
- Reset asserted mid-operation: outputs clear immediately (asynchronously). Programmed div_reg values are lost and return to the parameter values.
- Write-to-effect latency is bounded by one half-period (D cycles at the old divisor).

## Configuration
- CLKDIV_SYNC_EN defined:
  - enable and mode each pass through a 2-flop synchroniser, reset to 0, before use.
  - This adds 2 cycles of input latency and makes them safe to drive directly from push-buttons/switches.
- CLKDIV_SYNC_EN undefined: enable and mode are used directly and must be synchronous to clk. Cycle counts in the Test plan assume undefined.

## Test plan
- Reset, then enable=1, mode=1 (D=5):
  - clk_out rises on the 5th edge after release, then toggles every 5 cycles.
  - tick pulses 1 cycle wide every 5 cycles.
- mode 0->1 at counter=3 with slot 0 written to 20:
  - The current half-period completes at 20 cycles.
  - The next half-period is 5 cycles, with no short pulse.
- cfg_we, ch0 slot1 = 1:
  - After the current half-period, clk_out toggles every cycle and tick stays high.
  - Write to cfg_ch=5 with CHANNELS=2 changes nothing.
- enable=0 for 7 cycles mid-count:
  - clk_out and counter frozen, tick=0.
  - On resume, the half-period completes with total enabled cycles = D.
- Assert reset_n low asynchronously mid-half-period:
  - clk_out and tick are 0 before the next clk edge.
  - div_reg reads back DIV_FAST/DIV_SLOW behaviour afterwards.
- With CLKDIV_SYNC_EN defined, repeat the first scenario: the first clk_out rise shifts by exactly 2 cycles.
